// File: rtl/spi_link_master.sv
// rtl/spi_link_master.sv - SPI master with SCLK divider, CPOL/CPHA, bit order and multi-slave select hold
module spi_link_master #(
  parameter int DATA_W  = 8,
  parameter int NUM_SS  = 1,
  parameter int CLK_DIV = 4,
  parameter int SEL_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              hold_ss,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  input  logic              MISO,
  output logic              MOSI,
  output logic              SCLK,
  output logic [NUM_SS-1:0] SS_n
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
  localparam logic [SEL_W:0]    SS_LIMIT  = (SEL_W + 1)'(NUM_SS);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, TRAIL} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                lsb_q, lsb_d;
  logic                hold_q, hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mosi_q, mosi_d;
  logic                sclk_q, sclk_d;
  logic [NUM_SS-1:0]   ss_n_q, ss_n_d;

  logic                accept;
  logic                tick;
  logic                leading;
  logic                tx_head, in_head;
  logic [DATA_W-1:0]   tx_next, in_next, rx_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      edge_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mosi_q    <= 1'b0;
      sclk_q    <= 1'b0;
      ss_n_q    <= '1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mosi_q    <= mosi_d;
      sclk_q    <= sclk_d;
      ss_n_q    <= ss_n_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    edge_d    = edge_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mosi_d    = mosi_q;
    sclk_d    = sclk_q;
    ss_n_d    = ss_n_q;

    accept  = start && (state_q == IDLE) && ({1'b0, ss_sel} < SS_LIMIT);
    tick    = (div_q == DIV_LAST);
    leading = ~edge_q[0];
    tx_head = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
    tx_next = lsb_q ? {1'b0, tx_sh_q[DATA_W-1:1]} : {tx_sh_q[DATA_W-2:0], 1'b0};
    in_head = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
    in_next = lsb_first ? {1'b0, tx_data[DATA_W-1:1]} : {tx_data[DATA_W-2:0], 1'b0};
    rx_next = lsb_q ? {MISO, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], MISO};

    if (state_q != IDLE) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (accept) begin
          state_d = SETUP;
          busy_d  = 1'b1;
          div_d   = '0;
          edge_d  = '0;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          hold_d  = hold_ss;
          rx_sh_d = '0;
          // Rewriting the whole vector drops any other held select and keeps a re-selected one low.
          ss_n_d         = '1;
          ss_n_d[ss_sel] = 1'b0;
          if (!cpha) begin
            mosi_d  = in_head;
            tx_sh_d = in_next;
          end else begin
            tx_sh_d = tx_data;
          end
        end
      end
      SETUP, SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_W'(1);
          // Sample on the leading edge for cpha=0, on the trailing edge for cpha=1; drive on the other.
          if (leading ^ cpha_q) begin
            rx_sh_d = rx_next;
          end else if (cpha_q || (edge_q != EDGE_LAST)) begin
            mosi_d  = tx_head;
            tx_sh_d = tx_next;
          end
          if (state_q == SETUP) begin
            state_d = SHIFT;
          end else if (edge_q == EDGE_LAST) begin
            state_d = TRAIL;
          end
        end else if (state_q == SETUP) begin
          sclk_d = cpol_q;
        end
      end
      TRAIL: begin
        sclk_d = cpol_q;
        if (tick) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          rx_data_d = rx_sh_q;
          if (!hold_q) begin
            ss_n_d = '1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign MOSI    = mosi_q;
  assign SCLK    = sclk_q;
  assign SS_n    = ss_n_q;

endmodule
